bias_seq: RTL

BIAS_SEQ -- requirements
Module: bias_seq

---
 rtl/bias_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bias_seq.sv
// bias_seq: streams the bias words of one layer out of the b_mem bias buses.
// A start in IDLE latches the layer and data set and drives the b_mem choice
// lines. The words of that layer then go out as a valid/ready stream, and a
// one-cycle done pulse follows the last word.
// Optional feature: define BIAS_SEQ_ABORT_EN to add an abort input. That input
// cancels a running sequence without a done pulse.
module bias_seq #(
  parameter int WIDTH  = 32,
  parameter int N_G_L2 = 3,
  parameter int N_G_L3 = 9,
  parameter int N_D_L2 = 3,
  parameter int N_D_L3 = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              layer_sel,
  input  logic                    set_sel,
  output logic [3:0]              choice,
  input  logic [N_G_L2*WIDTH-1:0] bg2,
  input  logic [N_G_L3*WIDTH-1:0] bg3,
  input  logic [N_D_L2*WIDTH-1:0] bd2,
  input  logic [N_D_L3*WIDTH-1:0] bd3,
  output logic [WIDTH-1:0]        b_data,
  output logic [3:0]              b_idx,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic                    b_last,
`ifdef BIAS_SEQ_ABORT_EN
  input  logic                    abort,
`endif
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  state_t           state;
  logic [1:0]       layer_reg;
  logic             abort_int;
  logic [3:0]       nxt_idx;
  logic             nxt_last;
  logic [WIDTH-1:0] elem;
  int               n_layer;
  int               sel;

`ifdef BIAS_SEQ_ABORT_EN
  assign abort_int = abort;
`else
  assign abort_int = 1'b0;
`endif

  // Select the next word to present from the latched layer.
  // LOAD fetches element 0. STREAM fetches the element after the current one.
  // The index is clamped so that the part-select never leaves the bus.
  always_comb begin
    nxt_idx = (state == LOAD) ? 4'd0 : b_idx + 4'd1;
    case (layer_reg)
      2'd0:    n_layer = N_G_L2;
      2'd1:    n_layer = N_G_L3;
      2'd2:    n_layer = N_D_L2;
      default: n_layer = N_D_L3;
    endcase
    sel = int'(nxt_idx);
    if (sel >= n_layer) sel = 0;
    elem = '0;
    case (layer_reg)
      2'd0:    elem = bg2[sel*WIDTH +: WIDTH];
      2'd1:    elem = bg3[sel*WIDTH +: WIDTH];
      2'd2:    elem = bd2[sel*WIDTH +: WIDTH];
      default: elem = bd3[sel*WIDTH +: WIDTH];
    endcase
    nxt_last = (int'(nxt_idx) == n_layer - 1);
  end

  // Sequencer FSM. All outputs are registered, so the bias buses never reach
  // b_data through combinational logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      layer_reg <= 2'd0;
      choice    <= 4'd0;
      b_data    <= '0;
      b_idx     <= 4'd0;
      b_valid   <= 1'b0;
      b_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort_int) begin
            layer_reg <= layer_sel;
            choice    <= 4'({3'b000, set_sel}) << layer_sel;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (abort_int) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            b_data  <= elem;
            b_idx   <= 4'd0;
            b_valid <= 1'b1;
            b_last  <= nxt_last;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (abort_int) begin
            b_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (b_valid && b_ready) begin
            if (b_last) begin
              b_valid <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              b_idx  <= nxt_idx;
              b_data <= elem;
              b_last <= nxt_last;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
